// File: rtl/fetch_stage_pkg.sv
// Shared CPU types for the fetch stage: word type, fetch FSM states, PC constants.
package fetch_stage_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_INCR         = 32'd4;
  localparam word_t WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // Redirect targets are always forced onto a word boundary.
  function automatic word_t word_align(input word_t a);
    return a & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: icache read port, execute redirect, decode handoff.
// master = fetch stage, slave = icache/decode/execute side.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic  ihit;
  word_t iload;
  logic  iREN;
  word_t iaddr;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  halt_in;
  word_t instru;
  word_t nPC;
  logic  fvalid;
  logic  flush;

  modport master (
    input  ihit, iload, stall, redirect, redirect_pc, halt_in,
    output iREN, iaddr, instru, nPC, fvalid, flush
  );

  modport slave (
    output ihit, iload, stall, redirect, redirect_pc, halt_in,
    input  iREN, iaddr, instru, nPC, fvalid, flush
  );

endinterface

// File: rtl/fetch_perf_counters.sv
// Fetch performance counters: delivered instructions and stalled-valid cycles.
// Only instantiated when FETCH_PERF_EN is defined. Both counters wrap at 2^32.
module fetch_perf_counters
  import fetch_stage_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  fvalid,
  input  logic  stall,
  output word_t fetch_cnt,
  output word_t stall_cnt
);

  word_t r_fetch_cnt;
  word_t r_stall_cnt;

  // Count consumed vs. held output-register cycles.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (fvalid && !stall) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (fvalid &&  stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, icache request, one-entry output register to decode,
// redirect/miss-drain/halt FSM. Optional counters under FETCH_PERF_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  nRST,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output word_t fetch_cnt,
  output word_t stall_cnt
`endif
);

  fetch_state_t r_state, w_state_nx;
  word_t        r_pc, w_pc_nx;
  word_t        r_tgt, w_tgt_nx;
  word_t        r_instru, w_instru_nx;
  word_t        r_npc, w_npc_nx;
  logic         r_fvalid, w_fvalid_nx;

  logic  w_free;
  logic  w_req;
  word_t w_pc_plus4;
  word_t w_rtgt;

  assign w_free     = !r_fvalid || !bus.stall;
  // Request stays up in DRAIN so the icache sees a stable address until its miss completes.
  assign w_req      = ((r_state == RUN) && w_free) || (r_state == DRAIN);
  assign w_pc_plus4 = r_pc + PC_INCR;
  assign w_rtgt     = word_align(bus.redirect_pc);

  assign bus.iREN   = nRST && w_req;
  assign bus.iaddr  = r_pc;
  assign bus.flush  = nRST && bus.redirect;
  assign bus.instru = r_instru;
  assign bus.nPC    = r_npc;
  assign bus.fvalid = r_fvalid;

  // Next-state logic; a redirect outranks a halt because the halt is younger and squashed.
  always_comb begin
    w_state_nx  = r_state;
    w_pc_nx     = r_pc;
    w_tgt_nx    = r_tgt;
    w_instru_nx = r_instru;
    w_npc_nx    = r_npc;
    w_fvalid_nx = r_fvalid;
    case (r_state)
      RUN: begin
        if (bus.redirect) begin
          w_fvalid_nx = 1'b0;
          if (w_req && !bus.ihit) begin
            w_tgt_nx   = w_rtgt;
            w_state_nx = DRAIN;
          end else begin
            w_pc_nx = w_rtgt;
          end
        end else if (bus.halt_in) begin
          w_state_nx  = HALTED;
          w_fvalid_nx = 1'b0;
        end else if (w_req && bus.ihit) begin
          w_instru_nx = bus.iload;
          w_npc_nx    = w_pc_plus4;
          w_fvalid_nx = 1'b1;
          w_pc_nx     = w_pc_plus4;
        end else if (r_fvalid && !bus.stall) begin
          w_fvalid_nx = 1'b0;
        end
      end
      DRAIN: begin
        w_fvalid_nx = 1'b0;
        if (bus.redirect) w_tgt_nx = w_rtgt;
        if (bus.ihit) begin
          // The newest target wins when a redirect lands on the completing cycle.
          w_pc_nx    = bus.redirect ? w_rtgt : r_tgt;
          w_state_nx = RUN;
        end
      end
      HALTED: begin
        w_fvalid_nx = 1'b0;
      end
      default: begin
        w_state_nx  = RUN;
        w_fvalid_nx = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state  <= RUN;
      r_pc     <= RESET_PC;
      r_tgt    <= '0;
      r_instru <= '0;
      r_npc    <= '0;
      r_fvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_pc     <= w_pc_nx;
      r_tgt    <= w_tgt_nx;
      r_instru <= w_instru_nx;
      r_npc    <= w_npc_nx;
      r_fvalid <= w_fvalid_nx;
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_counters u_perf (
    .CLK       (CLK),
    .nRST      (nRST),
    .fvalid    (r_fvalid),
    .stall     (bus.stall),
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
  );
`endif

endmodule
